alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the 8-bit combinational ALU: accepts {op,a,b} commands over valid/ready,
//  buffers them in a small FIFO, drives registered A/B/select into the ALU, and captures
//  out/mul/carry into a valid/ready response port.
//  Screens divide-by-zero before issue. One command in flight at a time.
// PARAMETERS
//  FIFO_DEPTH  4      command FIFO entries; power of two, >=2
//  ERR_VALUE   8'hFF  rsp_result returned for divide-by-zero
// PORTS
//  clk         in   1   single clock; all state updates on rising edge
//  rst         in   1   synchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   FIFO can accept (= !full, registered state only)
//  cmd_op      in   4   ALU select code
//  cmd_a       in   8   operand A
//  cmd_b       in   8   operand B
//  cmd_acc     in   1   use accumulator as A (ALU_ACC_FWD_EN only; ignored otherwise)
//  alu_a       out  8   registered operand A to ALU
//  alu_b       out  8   registered operand B to ALU
//  alu_sel     out  4   registered select to ALU
//  alu_out     in   8   ALU result
//  alu_mul     in   16  ALU full product
//  alu_carry   in   1   ALU carry flag
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   consumer accepts response
//  rsp_result  out  8   captured result
//  rsp_hi      out  8   alu_mul[15:8] for op 4'b0010, else 0
//  rsp_carry   out  1   alu_carry for ops 4'b0000/4'b0010, else 0
//  rsp_err     out  1   divide-by-zero flag
//  busy        out  1   state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 after the reset cycle. Reset clears the FIFO,
//   state=IDLE, the accumulator, and drops any in-flight command. Reset is legal in any state.
//  FIFO: push when cmd_valid&&cmd_ready; pop in IDLE when non-empty.
//   Push and pop in the same cycle are legal; count is unchanged.
//   When full, cmd_ready=0 and there is no pass-through. Pointers wrap modulo FIFO_DEPTH.
//  FSM IDLE -> EXEC -> RESP.
//   IDLE: if non-empty, pop and load alu_a/alu_b/alu_sel, then go to EXEC.
//    If op==4'b0011 && b==0: set a pending error and load alu_b with 1, not 0, so the ALU never sees /0.
//   EXEC: capture the response regs from ALU inputs, set rsp_valid=1, go to RESP.
//    For a pending error, capture result=ERR_VALUE, hi=0, carry=0, err=1 instead.
//   RESP: hold all rsp_* stable while rsp_valid&&!rsp_ready.
//    On handshake: rsp_valid=0, go to IDLE. Next pop is in the following cycle.
//  Latency: command accepted at edge E0 into an empty idle block gives rsp_valid=1 after edge E2.
//   Throughput: 1 command per 3 cycles with rsp_ready held high.
//  alu_* hold their last values outside EXEC; the ALU is purely combinational and settles within one cycle.
//  Width rules: rsp_result=alu_out verbatim (no truncation logic here); rsp_hi takes bits 15:8 only.
// CONFIGURATION
//  ALU_ACC_FWD_EN defined:
//   An 8-bit accumulator register loads rsp_result on every response handshake; err responses do not update it.
//   A command with cmd_acc=1 issues alu_a=accumulator, read at pop time; cmd_a is ignored.
//   The FIFO stores cmd_acc alongside the command.
//  ALU_ACC_FWD_EN undefined:
//   No accumulator exists. cmd_acc is unconnected and not stored; alu_a=cmd_a always.
// STRUCTURE
//  Shared header alu_defs.vh:
//   - opcode localparams OP_ADD=4'b0000, OP_SUB=4'b0001, OP_MUL=4'b0010, OP_DIV=4'b0011 ... OP_EQ=4'b1111
//   - FSM state encodings S_IDLE/S_EXEC/S_RESP
//   - command field widths
//  Sub-module alu_cmd_fifo:
//   - generic synchronous FIFO (WIDTH, DEPTH)
//   - full/empty flags from a count register
//  Top level holds the FSM, screening, response regs and accumulator; the ALU is instantiated by the parent.
// TESTING
//  1 Reset mid-RESP with rsp_ready=0, then release:
//    -> rsp_valid=0, busy=0, cmd_ready=1, and no stale response afterwards.
//  2 Command MUL a=8'd20 b=8'd20, rsp_ready=1:
//    -> rsp_valid 2 cycles after accept; result=8'h90, hi=8'h01, carry=1, err=0.
//  3 Command DIV a=8'd7 b=0:
//    -> alu_b never 0; result=8'hFF, err=1, carry=0.
//    Follow with DIV 100/7 -> result=8'd14, err=0.
//  4 rsp_ready=0, push 5 commands back-to-back (FIFO_DEPTH=4):
//    -> cmd_ready drops after 4 accepts with the 5th held, rsp_* stable across stall.
//    Then release -> all 5 responses return in order.
//  5 Push and pop in the same cycle with the FIFO at depth-1, then at full:
//    -> count unchanged; cmd_ready reflects full only; no loss or duplication across pointer wrap.
//  6 (ALU_ACC_FWD_EN) SUB 50-8, then ADD acc=1 b=... :
//    -> alu_a=8'd42 on second issue. Build without the macro -> alu_a=cmd_a.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and the queued command.
// The stored command carries the accumulator-select bit only when ALU_ACC_FWD_EN is defined.
package alu_cmd_sequencer_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
`ifdef ALU_ACC_FWD_EN
    logic              acc;
`endif
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// Full/empty come from an occupancy counter so push and pop may coincide at any fill level.
module alu_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is dropped even when a pop happens on the same edge.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit combinational ALU: queues commands, screens divide-by-zero, captures responses.
// Define ALU_ACC_FWD_EN to add the accumulator that can replace operand A.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  ERR_VALUE  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_acc,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic [15:0] alu_mul,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic [7:0]  rsp_hi,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        busy
);

  state_t state;
  state_t state_next;
  cmd_t   push_cmd;
  cmd_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;
  logic   capture;
  logic   rsp_hs;
  logic   pend_err;
  logic   unused_bits;

  assign push_cmd.op = cmd_op;
  assign push_cmd.a  = cmd_a;
  assign push_cmd.b  = cmd_b;
`ifdef ALU_ACC_FWD_EN
  logic [7:0] acc_q;
  assign push_cmd.acc = cmd_acc;
  assign unused_bits  = ^alu_mul[7:0];
`else
  assign unused_bits  = ^{alu_mul[7:0], cmd_acc};
`endif

  alu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (state == S_IDLE) && !fifo_empty;
    capture   = (state == S_EXEC);
    rsp_hs    = (state == S_RESP) && rsp_ready;
    rsp_valid = (state == S_RESP);
    busy      = (state != S_IDLE) || !fifo_empty;
    cmd_ready = !fifo_full;
  end

  // A zero divisor is swapped for 1 so the ALU never divides by zero; the error is reported instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      pend_err <= 1'b0;
    end else if (fifo_pop) begin
      alu_sel <= head.op;
`ifdef ALU_ACC_FWD_EN
      alu_a   <= head.acc ? acc_q : head.a;
`else
      alu_a   <= head.a;
`endif
      if (head.op == OP_DIV && head.b == 8'd0) begin
        alu_b    <= 8'd1;
        pend_err <= 1'b1;
      end else begin
        alu_b    <= head.b;
        pend_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_hi     <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (capture) begin
      if (pend_err) begin
        rsp_result <= ERR_VALUE;
        rsp_hi     <= '0;
        rsp_carry  <= 1'b0;
        rsp_err    <= 1'b1;
      end else begin
        rsp_result <= alu_out;
        rsp_hi     <= (alu_sel == OP_MUL) ? alu_mul[15:8] : 8'd0;
        rsp_carry  <= (alu_sel == OP_ADD || alu_sel == OP_MUL) ? alu_carry : 1'b0;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_ACC_FWD_EN
  // Only good results feed the accumulator; an error response leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst)                      acc_q <= '0;
    else if (rsp_hs && !rsp_err)  acc_q <= rsp_result;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small reference ALU and an in-order response scoreboard.
// Works with or without ALU_ACC_FWD_EN defined.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [7:0] result;
    logic [7:0] hi;
    logic       carry;
    logic       err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        cmd_acc;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic [15:0] alu_mul;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic [7:0]  rsp_hi;
  logic        rsp_carry;
  logic        rsp_err;
  logic        busy;

  int   checks   = 0;
  int   failures = 0;
  rsp_t expq[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.FIFO_DEPTH(4), .ERR_VALUE(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_acc    (cmd_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_mul    (alu_mul),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_hi     (rsp_hi),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Stand-in for the parent's combinational ALU.
  always_comb begin
    alu_mul   = {8'd0, alu_a} * {8'd0, alu_b};
    alu_out   = alu_a ^ alu_b;
    alu_carry = 1'b0;
    case (alu_sel)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      4'b0010: begin alu_out = alu_mul[7:0]; alu_carry = |alu_mul[15:8]; end
      4'b0011: alu_out = (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Every response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin : scoreboard
    rsp_t e;
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_rsp", 1, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("rsp_result", rsp_result, e.result);
        checkOutput("rsp_hi",     rsp_hi,     e.hi);
        checkOutput("rsp_carry",  rsp_carry,  e.carry);
        checkOutput("rsp_err",    rsp_err,    e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    cmd_valid = 1'b1;
  endtask

  task automatic pushCmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic acc, input rsp_t e);
    int n = 0;
    applyStimulus(op, a, b, acc);
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) checkOutput("push_timeout", 0, 1);
    else begin step(); expq.push_back(e); end
    cmd_valid = 1'b0;
  endtask

  task automatic waitRspValid(input string tag);
    int n = 0;
    while (!rsp_valid && n < 50) begin step(); n++; end
    if (!rsp_valid) checkOutput(tag, 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while (expq.size() > 0 && n < 200) begin step(); n++; end
    if (expq.size() != 0) checkOutput("drain_timeout", expq.size(), 0);
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] v_op  [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0000};
  logic [7:0] v_a   [5] = '{8'd10,   8'd200,  8'd16,   8'd5,    8'd255};
  logic [7:0] v_b   [5] = '{8'd20,   8'd100,  8'd17,   8'd9,    8'd1};
  rsp_t       v_exp [5] = '{'{8'd30, 8'd0, 1'b0, 1'b0}, '{8'd44, 8'd0, 1'b1, 1'b0},
                            '{8'h10, 8'h01, 1'b1, 1'b0}, '{8'hFC, 8'd0, 1'b0, 1'b0},
                            '{8'd0,  8'd0, 1'b1, 1'b0}};

  initial begin : main
    int         accepted;
    int         n;
    logic [7:0] snap_res;
    logic [7:0] snap_hi;
    logic       snap_c;
    logic       snap_e;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_acc = 1'b0;
    rsp_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_result", rsp_result, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_sel", alu_sel, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);

    // Reset while a response is stalled.
    pushCmd(4'b0000, 8'd1, 8'd2, 1'b0, '{8'd3, 8'd0, 1'b0, 1'b0});
    waitRspValid("t1_rsp_timeout");
    rst = 1'b1; step(); rst = 1'b0;
    expq.delete();
    checkOutput("t1_rsp_valid", rsp_valid, 0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    repeat (10) step();
    checkOutput("t1_stale_valid", rsp_valid, 0);

    // MUL 20*20 with two-cycle latency.
    applyStimulus(4'b0010, 8'd20, 8'd20, 1'b0);
    step();
    cmd_valid = 1'b0;
    expq.push_back('{8'h90, 8'h01, 1'b1, 1'b0});
    checkOutput("t2_lat_e0", rsp_valid, 0);
    step();
    checkOutput("t2_lat_e1", rsp_valid, 0);
    step();
    checkOutput("t2_lat_e2", rsp_valid, 1);
    step();
    checkOutput("t2_done", rsp_valid, 0);

    // Divide by zero screening, then a normal divide.
    rsp_ready = 1'b0;
    pushCmd(4'b0011, 8'd7, 8'd0, 1'b0, '{8'hFF, 8'd0, 1'b0, 1'b1});
    waitRspValid("t3_rsp_timeout");
    checkOutput("t3_alu_b_nonzero", alu_b, 1);
    checkOutput("t3_alu_sel", alu_sel, 4'b0011);
    drain();
    pushCmd(4'b0011, 8'd100, 8'd7, 1'b0, '{8'd14, 8'd0, 1'b0, 1'b0});
    drain();

    // Back-to-back pushes against a stalled response.
    rsp_ready = 1'b0;
    pushCmd(4'b0001, 8'd9, 8'd4, 1'b0, '{8'd5, 8'd0, 1'b0, 1'b0});
    waitRspValid("t4_rsp_timeout");
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(v_op[i], v_a[i], v_b[i], 1'b0);
      if (!cmd_ready) break;
      step();
      accepted++;
      expq.push_back(v_exp[i]);
    end
    checkOutput("t4_accepted", accepted, 4);
    checkOutput("t4_full_ready", cmd_ready, 0);
    snap_res = rsp_result; snap_hi = rsp_hi; snap_c = rsp_carry; snap_e = rsp_err;
    repeat (3) step();
    checkOutput("t4_stall_valid", rsp_valid, 1);
    checkOutput("t4_stall_all", {rsp_result, rsp_hi, rsp_carry, rsp_err},
                {snap_res, snap_hi, snap_c, snap_e});
    checkOutput("t4_stall_result", rsp_result, 8'd5);
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) checkOutput("t4_fifth_timeout", 0, 1);
    else begin step(); expq.push_back(v_exp[4]); end
    cmd_valid = 1'b0;
    drain();

    // Simultaneous push and pop at depth-1, then at full.
    rsp_ready = 1'b0;
    pushCmd(4'b0000, 8'd1, 8'd1, 1'b0, '{8'd2, 8'd0, 1'b0, 1'b0});
    waitRspValid("t5_rsp_timeout_a");
    pushCmd(4'b0000, 8'd2, 8'd2, 1'b0, '{8'd4, 8'd0, 1'b0, 1'b0});
    pushCmd(4'b0000, 8'd3, 8'd3, 1'b0, '{8'd6, 8'd0, 1'b0, 1'b0});
    pushCmd(4'b0000, 8'd4, 8'd4, 1'b0, '{8'd8, 8'd0, 1'b0, 1'b0});
    checkOutput("t5_depth3_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    applyStimulus(4'b0000, 8'd5, 8'd5, 1'b0);
    step();
    cmd_valid = 1'b0;
    expq.push_back('{8'd10, 8'd0, 1'b0, 1'b0});
    checkOutput("t5_pp_depth3_ready", cmd_ready, 1);
    checkOutput("t5_busy", busy, 1);
    pushCmd(4'b0000, 8'd6, 8'd6, 1'b0, '{8'd12, 8'd0, 1'b0, 1'b0});
    checkOutput("t5_full_ready", cmd_ready, 0);
    waitRspValid("t5_rsp_timeout_b");
    rsp_ready = 1'b1;
    applyStimulus(4'b0000, 8'd7, 8'd7, 1'b0);
    step();
    rsp_ready = 1'b0;
    checkOutput("t5_full_hs_ready", cmd_ready, 0);
    step();
    checkOutput("t5_full_pop_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    expq.push_back('{8'd14, 8'd0, 1'b0, 1'b0});
    checkOutput("t5_refull_ready", cmd_ready, 0);
    drain();

    // Accumulator forwarding (plain operand A when the feature is absent).
    pushCmd(4'b0001, 8'd50, 8'd8, 1'b0, '{8'd42, 8'd0, 1'b0, 1'b0});
    drain();
    pushCmd(4'b0011, 8'd1, 8'd0, 1'b0, '{8'hFF, 8'd0, 1'b0, 1'b1});
    drain();
    rsp_ready = 1'b0;
`ifdef ALU_ACC_FWD_EN
    pushCmd(4'b0000, 8'd3, 8'd5, 1'b1, '{8'd47, 8'd0, 1'b0, 1'b0});
    waitRspValid("t6_rsp_timeout");
    checkOutput("t6_alu_a_acc", alu_a, 8'd42);
`else
    pushCmd(4'b0000, 8'd3, 8'd5, 1'b1, '{8'd8, 8'd0, 1'b0, 1'b0});
    waitRspValid("t6_rsp_timeout");
    checkOutput("t6_alu_a_cmd", alu_a, 8'd3);
`endif
    drain();
    checkOutput("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
